// File: rtl/systolic_array_controller.sv
//------------------------------------------------------------------------------
// Module   : systolic_array_controller
// Brief    : Clear / diagonal-wavefront read / lagged write sequencer for an
//            N x N output-stationary systolic array.
// Macro    : SYSTOLIC_CTRL_RESTART_EN (init outside IDLE restarts at CLEAR)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package systolic_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_e;
endpackage

module systolic_ctrl_fsm
  import systolic_ctrl_pkg::*;
#(
  parameter int N  = 5,
  parameter int TW = $clog2(3 * N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  output state_e        state,
  output logic [TW-1:0] r_t
);

  localparam logic [TW-1:0] c_last = TW'(3 * N - 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r_t   <= '0;
    end else begin
`ifdef SYSTOLIC_CTRL_RESTART_EN
      if (init && (state != IDLE)) begin
        state <= CLEAR;
        r_t   <= '0;
      end else
`endif
      case (state)
        IDLE: begin
          r_t <= '0;
          if (init) state <= CLEAR;
        end
        CLEAR: begin
          state <= RUN;
          r_t   <= '0;
        end
        RUN: begin
          if (r_t == c_last) begin
            state <= DONE;
            r_t   <= '0;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          r_t   <= '0;
        end
        default: begin
          state <= IDLE;
          r_t   <= '0;
        end
      endcase
    end
  end

endmodule

module systolic_array_controller
  import systolic_ctrl_pkg::*;
#(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init,
  output logic [N*N-1:0] read,
  output logic [N*N-1:0] write,
  output logic [N*N-1:0] clr
);

  localparam int TW = $clog2(3 * N);

  state_e          state;
  logic [TW-1:0]   r_t;
  logic [31:0]     w_t;
  logic            w_run;

  systolic_ctrl_fsm #(
    .N  (N),
    .TW (TW)
  ) C1 (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (init),
    .state (state),
    .r_t   (r_t)
  );

  assign w_t   = 32'(r_t);
  assign w_run = (state == RUN);
  assign clr   = {(N*N){state == CLEAR}};

  // Window tests use wrapping subtraction: (t - lo) < N  <=>  lo <= t <= lo+N-1.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam logic [31:0] c_rd_lo = 32'(r + c);
      localparam logic [31:0] c_wr_lo = 32'(r + c + 1);
      assign read[r*N+c]  = w_run && ((w_t - c_rd_lo) < 32'(N));
      assign write[r*N+c] = w_run && ((w_t - c_wr_lo) < 32'(N));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_systolic_array_controller
// Brief    : Directed self-checking bench for systolic_array_controller (N=5).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_systolic_array_controller;

  localparam int N  = 5;
  localparam int NN = N * N;

  logic          clk;
  logic          rst_n;
  logic          init;
  logic [NN-1:0] read;
  logic [NN-1:0] write;
  logic [NN-1:0] clr;

  int checks = 0;
  int errors = 0;

  systolic_array_controller #(.N(N)) DUT (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (init),
    .read  (read),
    .write (write),
    .clr   (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NN-1:0] exp_rd(input int t);
    logic [NN-1:0] v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[r*N+c] = (r + c <= t) && (t <= r + c + N - 1);
    return v;
  endfunction

  function automatic logic [NN-1:0] exp_wr(input int t);
    logic [NN-1:0] v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[r*N+c] = (r + c + 1 <= t) && (t <= r + c + N);
    return v;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(DUT.C1.state), 32'h0);
    chk({tag, "_read"},  32'(read),  32'h0);
    chk({tag, "_write"}, 32'(write), 32'h0);
    chk({tag, "_clr"},   32'(clr),   32'h0);
  endtask

  task automatic pulse_init();
    @(negedge clk) init = 1'b1;
    @(negedge clk) init = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (DUT.C1.state !== 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reached_idle"}, 32'(DUT.C1.state === 2'b00), 32'h1);
  endtask

  initial begin
    int rc[NN];
    int wc[NN];
    int cc[NN];
    int overlap;
    int cnt_bad;

    rst_n = 1'b0;
    init  = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("post_reset_idle");

    // Full sequence; k=0 CLEAR, k=1..14 RUN t=k-1, k=15 DONE, k=16 IDLE
    foreach (rc[i]) begin rc[i] = 0; wc[i] = 0; cc[i] = 0; end
    overlap = 0;
    pulse_init();
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < NN; i++) begin
        rc[i] += int'(read[i]);
        wc[i] += int'(write[i]);
        cc[i] += int'(clr[i]);
        if (clr[i] && (read[i] || write[i])) overlap++;
      end
      case (k)
        0: begin
          chk("start_state", 32'(DUT.C1.state), 32'h1);
          chk("start_clr",   32'(clr),   32'h1FFFFFF);
          chk("start_read",  32'(read),  32'h0);
          chk("start_write", 32'(write), 32'h0);
        end
        1: begin
          chk("t0_read",  32'(read),  32'h0000001);
          chk("t0_write", 32'(write), 32'h0);
          chk("t0_clr",   32'(clr),   32'h0);
        end
        2: begin
          chk("t1_read",  32'(read),  32'h0000023);
          chk("t1_write", 32'(write), 32'h0000001);
        end
        13: begin
          chk("t12_read",  32'(read),  32'h1000000);
          chk("t12_write", 32'(write), 32'h1880000);
        end
        14: begin
          chk("t13_state", 32'(DUT.C1.state), 32'h2);
          chk("t13_read",  32'(read),  32'h0);
          chk("t13_write", 32'(write), 32'h1000000);
        end
        15: begin
          chk("done_state", 32'(DUT.C1.state), 32'h3);
          chk("done_read",  32'(read),  32'h0);
          chk("done_write", 32'(write), 32'h0);
          chk("done_clr",   32'(clr),   32'h0);
        end
        16: chk_idle("end_idle");
        default: begin
          chk($sformatf("run_t%0d_state", k - 1), 32'(DUT.C1.state), 32'h2);
          chk($sformatf("run_t%0d_read", k - 1),  32'(read),  32'(exp_rd(k - 1)));
          chk($sformatf("run_t%0d_write", k - 1), 32'(write), 32'(exp_wr(k - 1)));
        end
      endcase
    end
    cnt_bad = 0;
    for (int i = 0; i < NN; i++)
      if (rc[i] != 5 || wc[i] != 5 || cc[i] != 1) cnt_bad++;
    chk("per_pe_counts_bad", 32'(cnt_bad), 32'h0);
    chk("clr_rw_overlap", 32'(overlap), 32'h0);
    repeat (2) @(negedge clk);
    chk_idle("stay_idle");

    // Re-init at RUN t=5
    pulse_init();
    repeat (6) @(negedge clk);
    chk("reinit_pre_read", 32'(read), 32'(exp_rd(5)));
    init = 1'b1;
    @(negedge clk) init = 1'b0;
`ifdef SYSTOLIC_CTRL_RESTART_EN
    chk("reinit_state", 32'(DUT.C1.state), 32'h1);
    chk("reinit_clr",   32'(clr),  32'h1FFFFFF);
    chk("reinit_read",  32'(read), 32'h0);
    @(negedge clk);
    chk("reinit_t0_read", 32'(read), 32'h0000001);
`else
    chk("reinit_state", 32'(DUT.C1.state), 32'h2);
    chk("reinit_read",  32'(read),  32'(exp_rd(6)));
    chk("reinit_write", 32'(write), 32'(exp_wr(6)));
    chk("reinit_clr",   32'(clr),   32'h0);
`endif
    wait_idle("reinit");

    // Asynchronous reset in mid-RUN
    pulse_init();
    repeat (4) @(negedge clk);
    chk("prereset_state", 32'(DUT.C1.state), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_idle($sformatf("after_reset_c%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
